// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and the per-iteration step mode.
package mdu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_e;

   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply on {hi,lo=multiplier}, or
// restoring divide on {remainder,quotient=dividend}.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [2*N-1:0] i_acc,
   input  logic [N-1:0]   i_operand,
   input  step_mode_e     i_mode,
   output logic [2*N-1:0] o_acc
);

   logic [N:0]   w_sum;
   logic [N:0]   w_shifted;
   logic [N-1:0] w_diff;
   logic         w_ge;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_sum     = {1'b0, i_acc[2*N-1:N]} + {1'b0, i_operand};
      w_shifted = {i_acc[2*N-1:N], i_acc[N-1]};
      w_ge      = (w_shifted >= {1'b0, i_operand});
      // Only used when w_ge holds, so the result always fits in N bits.
      w_diff    = w_shifted[N-1:0] - i_operand;
      o_acc     = '0;
      if (i_mode == STEP_MUL) begin
         if (i_acc[0]) o_acc = {w_sum, i_acc[N-1:1]};
         else          o_acc = {1'b0, i_acc[2*N-1:1]};
      end else begin
         if (w_ge) o_acc = {w_diff, i_acc[N-2:0], 1'b1};
         else      o_acc = {w_shifted[N-1:0], i_acc[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit, one bit per cycle.
// Define MDU_SIGNED_EN to make MULT/DIV signed; otherwise they equal MULTU/DIVU.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   output logic            busy,
   output logic            done,
   output logic            dz,
   output logic [N-1:0]    hi,
   output logic [N-1:0]    lo
);

   localparam int CW = $clog2(N+1);

   state_e         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [OP_W-1:0] r_op;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_opnd;
   logic [2*N-1:0] r_acc;
   logic           r_mt_done;

   logic [2*N-1:0] w_step_acc;
   logic [2*N-1:0] w_prod;
   logic [N-1:0]   w_q, w_r;
   logic [N-1:0]   w_abs_a, w_abs_b;
   logic [N-1:0]   w_hi_res, w_lo_res;
   logic           w_accept, w_mt, w_last;
   step_mode_e     w_mode;

   assign w_accept = (r_state == IDLE) && start && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
   assign w_mt     = (r_state == IDLE) && start && (op inside {OP_MTHI, OP_MTLO});
   assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));
   assign w_mode   = is_div(r_op) ? STEP_DIV : STEP_MUL;

   mdu_step #(.N(N)) u_step (
      .i_acc     (r_acc),
      .i_operand (r_opnd),
      .i_mode    (w_mode),
      .o_acc     (w_step_acc)
   );

`ifdef MDU_SIGNED_EN
   logic w_neg_a, w_neg_b;
   logic r_neg_lo, r_neg_hi;

   always_comb begin
      w_neg_a = ((op == OP_MULT) || (op == OP_DIV)) && a[N-1];
      w_neg_b = ((op == OP_MULT) || (op == OP_DIV)) && b[N-1];
      w_abs_a = w_neg_a ? -a : a;
      w_abs_b = w_neg_b ? -b : b;
      // Product/quotient sign is the XOR of operand signs; remainder follows the dividend.
      w_prod  = r_neg_lo ? -w_step_acc : w_step_acc;
      w_q     = r_neg_lo ? -w_step_acc[N-1:0] : w_step_acc[N-1:0];
      w_r     = r_neg_hi ? -w_step_acc[2*N-1:N] : w_step_acc[2*N-1:N];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
      end else if (w_accept) begin
         r_neg_lo <= w_neg_a ^ w_neg_b;
         r_neg_hi <= w_neg_a;
      end
   end
`else
   always_comb begin
      w_abs_a = a;
      w_abs_b = b;
      w_prod  = w_step_acc;
      w_q     = w_step_acc[N-1:0];
      w_r     = w_step_acc[2*N-1:N];
   end
`endif

   always_comb begin
      w_hi_res = w_prod[2*N-1:N];
      w_lo_res = w_prod[N-1:0];
      if (is_div(r_op)) begin
         if (r_opnd == '0) begin
            w_hi_res = r_a;
            w_lo_res = '1;
         end else begin
            w_hi_res = w_r;
            w_lo_res = w_q;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != IDLE);
      done        = (r_state == FIN) || r_mt_done;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (w_last)   w_state_nxt = FIN;
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_a       <= '0;
         r_opnd    <= '0;
         r_acc     <= '0;
         r_mt_done <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         dz        <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mt_done <= w_mt;
         if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_cnt <= CW'(N);
            if (is_div(op)) begin
               r_opnd <= w_abs_b;
               r_acc  <= {{N{1'b0}}, w_abs_a};
            end else begin
               r_opnd <= w_abs_a;
               r_acc  <= {{N{1'b0}}, w_abs_b};
            end
         end else if (r_state == RUN) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_mt) begin
            if (op == OP_MTHI) hi <= a;
            else               lo <= a;
         end
         // Results land on the edge entering FIN so HI/LO are valid while done is high.
         if (w_last) begin
            hi <= w_hi_res;
            lo <= w_lo_res;
            if (is_div(r_op)) dz <= (r_opnd == '0);
         end
      end
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter N, default 32, operand/result width in bits; legal values are even and 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset: asserted low, acts immediately, released synchronously to clk.
REQ-004 start  input  1  operation request, sampled on rising clk edges.
REQ-005 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved.
REQ-006 a  input  N  multiplicand, dividend, or MTHI/MTLO data.
REQ-007 b  input  N  multiplier or divisor.
REQ-008 busy  output  1  high while an iterative operation runs.
REQ-009 done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-010 dz  output  1  sticky divide-by-zero flag from the last DIV/DIVU.
REQ-011 hi  output  N  HI register: product upper half or remainder.
REQ-012 lo  output  N  LO register: product lower half or quotient.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-014 In IDLE, start with op 0-3 SHALL latch a, b and op, load the step counter with N, and move to RUN.
REQ-015 In IDLE, start with MTHI/MTLO SHALL write a into hi/lo at that edge, leave the other register unchanged, stay in IDLE, and pulse done the next cycle.
REQ-016 In IDLE, start with op 6/7 SHALL be ignored: no state change, no done pulse.
REQ-017 RUN SHALL perform exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle, decrement the counter, and go to FIN after N steps.
REQ-018 FIN SHALL write hi/lo, assert done for that one cycle, and return to IDLE.
REQ-019 Latency: done SHALL be high in cycle N+1 after the start edge, which is cycle 0.
REQ-020 busy SHALL be high in RUN and FIN and low in IDLE.
REQ-021 start while busy SHALL be ignored, with no effect on operands or results.
REQ-022 hi/lo SHALL hold their previous values until FIN; all partial results live only in internal working registers.
REQ-023 MULT/MULTU: {hi,lo} SHALL equal the full 2N-bit product.
REQ-024 DIV/DIVU: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder, carrying the sign of the dividend.
REQ-025 Divide by zero: b==0 SHALL give lo=all ones, hi=a, dz=1, with the full normal latency.
REQ-026 A DIV/DIVU with b!=0 SHALL clear dz at FIN; MULT and MT* operations SHALL leave dz unchanged.
REQ-027 Signed overflow, DIV of most-negative a by -1, SHALL give lo=most-negative and hi=0.

Reset
REQ-028 reset low SHALL force state IDLE, hi=0, lo=0, busy=0, done=0, dz=0, and counter=0.
REQ-029 reset during RUN/FIN SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-030 Macro MDU_SIGNED_EN defined: MULT and DIV are signed, with operand sign correction before iteration and result negation at FIN.
REQ-031 MDU_SIGNED_EN undefined: no sign logic is synthesised; MULT behaves as MULTU and DIV behaves as DIVU, bit-exact.

Structure
REQ-032 Package mdu_pkg SHALL hold the op encoding enum, the state enum (IDLE/RUN/FIN), and the op-width constant (3).
REQ-033 Sub-module mdu_step SHALL be combinational and compute one multiply or divide iteration from (acc, operand, mode).
REQ-034 The counter width SHALL be $clog2(N+1).

Verification (N=32)
REQ-035 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, done exactly at cycle 33, busy high for cycles 1-33.
REQ-036 MULT a=FFFFFFFD (-3), b=5 -> hi=FFFFFFFF, lo=FFFFFFF1; with MDU_SIGNED_EN undefined -> hi=00000004, lo=FFFFFFF1.
REQ-037 DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF, dz=0.
REQ-038 DIVU a=64, b=0 -> lo=FFFFFFFF, hi=00000064, dz=1; a following DIVU 9/3 -> lo=3, hi=0, dz=0.
REQ-039 MTHI a=12345678 -> hi=12345678 at the next edge, lo unchanged, done pulsed once; a start at cycle 5 of a MULTU is ignored.
REQ-040 Reset low at cycle 10 of a DIVU -> hi=0, lo=0, busy=0 immediately, no done pulse; after release, MULTU 3*4 -> lo=C, hi=0.
